// File: rtl/branch_pred_pkg.sv
// -----------------------------------------------------------------------------
// branch_pred_pkg
// Shared types and helpers for the branch prediction core:
//   state_t  - sequencing states of the core (IDLE -> LOOKUP -> UPDATE)
//   ctr_init - reset value of a CTR_W-bit counter (weakly not-taken)
//   sat_inc  - saturating increment against an explicit ceiling
//   sat_dec  - saturating decrement with a floor of zero
// The helpers work on 32-bit values so they can serve both the table counters
// and the statistics counters; callers cast back to their own width.
// -----------------------------------------------------------------------------
package branch_pred_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        UPDATE = 2'd2
    } state_t;

    // Weakly not-taken: the value just below the taken threshold.
    function automatic logic [31:0] ctr_init(input int ctr_w);
        return 32'((64'd1 << (ctr_w - 1)) - 64'd1);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
        return (v >= max_v) ? v : (v + 32'd1);
    endfunction

    function automatic logic [31:0] sat_dec(input logic [31:0] v);
        return (v == 32'd0) ? v : (v - 32'd1);
    endfunction

endpackage

// File: rtl/branch_pred_core_if.sv
// -----------------------------------------------------------------------------
// branch_pred_core_if
// Record handshake between the SPI front-end (master) and the prediction
// core (slave).
//   in_valid               master -> slave  record available
//   in_ready               slave  -> master core can accept this cycle
//   inst_addr[ADDR_W]      master -> slave  branch instruction address
//   direction_ground_truth master -> slave  actual outcome, 1 = taken
// -----------------------------------------------------------------------------
interface branch_pred_core_if
    import branch_pred_pkg::*;
#(
    parameter int ADDR_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] inst_addr;
    logic              direction_ground_truth;

    modport master (
        output in_valid,
        output inst_addr,
        output direction_ground_truth,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  inst_addr,
        input  direction_ground_truth,
        output in_ready
    );
endinterface

// File: rtl/bp_counter_table.sv
// -----------------------------------------------------------------------------
// bp_counter_table
// Table of 2^IDX_W saturating counters, each CTR_W bits wide.
//   clk, rst        clock, asynchronous active-high reset (to ctr_init)
//   i_rd_idx        combinational read index
//   o_rd_ctr        counter value at i_rd_idx
//   i_wr_en         apply a training update this cycle
//   i_wr_idx        entry to train
//   i_wr_truth      1 = step counter up, 0 = step counter down (saturating)
// -----------------------------------------------------------------------------
module bp_counter_table
    import branch_pred_pkg::*;
#(
    parameter int IDX_W = 4,
    parameter int CTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [CTR_W-1:0] o_rd_ctr,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic             i_wr_truth
);
    localparam int               DEPTH    = 1 << IDX_W;
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(ctr_init(CTR_W));
    localparam logic [31:0]      CTR_MAX  = 32'((64'd1 << CTR_W) - 64'd1);

    logic [CTR_W-1:0] r_ctr [DEPTH];
    logic [CTR_W-1:0] w_wr_next;

    assign o_rd_ctr = r_ctr[i_rd_idx];

    // Next value of the entry being trained, clamped at both ends.
    always_comb begin
        w_wr_next = r_ctr[i_wr_idx];
        if (i_wr_truth) begin
            w_wr_next = CTR_W'(sat_inc(32'(r_ctr[i_wr_idx]), CTR_MAX));
        end else begin
            w_wr_next = CTR_W'(sat_dec(32'(r_ctr[i_wr_idx])));
        end
    end

    // Counter storage: every entry resets to weakly not-taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ctr[i] <= CTR_INIT;
            end
        end else if (i_wr_en) begin
            r_ctr[i_wr_idx] <= w_wr_next;
        end
    end

endmodule

// File: rtl/branch_pred_core.sv
// -----------------------------------------------------------------------------
// branch_pred_core
// Predicts branch direction from a table of saturating counters (bimodal when
// HIST_W=0, gshare otherwise), reports the prediction and whether it matched
// the ground truth, trains the table and keeps hit/miss statistics.
// One record is processed every three cycles: IDLE (accept), LOOKUP
// (predict), UPDATE (pred strobe, train, shift history, count).
//   clk, rst        clock, asynchronous active-high reset
//   bus (slave)     in_valid / in_ready / inst_addr / direction_ground_truth
//   i_clear_stats   synchronous clear of both statistics counters
//   o_pred_valid    one-cycle strobe while in UPDATE
//   o_pred_taken    predicted direction (counter MSB)
//   o_pred_correct  prediction equals ground truth
//   o_history       global history register (0 when HIST_W=0)
//   o_total_count   records processed (saturating)
//   o_miss_count    mispredictions (saturating)
// -----------------------------------------------------------------------------
module branch_pred_core
    import branch_pred_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int IDX_W  = 4,
    parameter int HIST_W = 4,
    parameter int CTR_W  = 2,
    parameter int STAT_W = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    branch_pred_core_if.slave                      bus,
    input  logic                                   i_clear_stats,
    output logic                                   o_pred_valid,
    output logic                                   o_pred_taken,
    output logic                                   o_pred_correct,
    output logic [((HIST_W > 0) ? HIST_W : 1)-1:0] o_history,
    output logic [STAT_W-1:0]                      o_total_count,
    output logic [STAT_W-1:0]                      o_miss_count
);
    localparam int          HW_EFF   = (HIST_W > 0) ? HIST_W : 1;
    localparam logic [31:0] STAT_MAX = 32'((64'd1 << STAT_W) - 64'd1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_truth;
    logic [IDX_W-1:0]  r_idx;
    logic [HW_EFF-1:0] r_hist;
    logic [STAT_W-1:0] r_total;
    logic [STAT_W-1:0] r_miss;
    logic              r_pred_valid;
    logic              r_pred_taken;
    logic              r_pred_correct;

    logic [IDX_W-1:0]  w_hist_fold;
    logic [HW_EFF-1:0] w_hist_next;
    logic [IDX_W-1:0]  w_lookup_idx;
    logic [CTR_W-1:0]  w_rd_ctr;
    logic              w_ctr_taken;
    logic              w_wr_en;
    logic              w_addr_unused;

    // Only the low IDX_W address bits index the table; the rest are latched
    // for completeness and deliberately left unused.
    assign w_addr_unused = ^r_addr;

    // History folding: zero-extend or truncate to IDX_W bits. With no history
    // the register is pinned to zero and indexing degenerates to bimodal.
    generate
        if (HIST_W == 0) begin : g_bimodal
            assign w_hist_fold = {IDX_W{1'b0}};
            assign w_hist_next = {HW_EFF{1'b0}};
        end else begin : g_gshare
            assign w_hist_fold = IDX_W'(r_hist);
            assign w_hist_next = HW_EFF'({r_hist, r_truth});
        end
    endgenerate

    assign w_lookup_idx = r_addr[IDX_W-1:0] ^ w_hist_fold;
    assign w_ctr_taken  = w_rd_ctr[CTR_W-1];
    assign w_wr_en      = (r_state == UPDATE);

    bp_counter_table #(
        .IDX_W (IDX_W),
        .CTR_W (CTR_W)
    ) u_tbl (
        .clk        (clk),
        .rst        (rst),
        .i_rd_idx   (w_lookup_idx),
        .o_rd_ctr   (w_rd_ctr),
        .i_wr_en    (w_wr_en),
        .i_wr_idx   (r_idx),
        .i_wr_truth (r_truth)
    );

    // Sequencer: capture, predict, then train; also owns history and stats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_addr         <= {ADDR_W{1'b0}};
            r_truth        <= 1'b0;
            r_idx          <= {IDX_W{1'b0}};
            r_hist         <= {HW_EFF{1'b0}};
            r_total        <= {STAT_W{1'b0}};
            r_miss         <= {STAT_W{1'b0}};
            r_pred_valid   <= 1'b0;
            r_pred_taken   <= 1'b0;
            r_pred_correct <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_addr  <= bus.inst_addr;
                        r_truth <= bus.direction_ground_truth;
                        r_state <= LOOKUP;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                LOOKUP: begin
                    // The index is kept so training hits the entry that predicted.
                    r_idx          <= w_lookup_idx;
                    r_pred_taken   <= w_ctr_taken;
                    r_pred_correct <= (w_ctr_taken == r_truth);
                    r_pred_valid   <= 1'b1;
                    r_state        <= UPDATE;
                end
                UPDATE: begin
                    r_pred_valid <= 1'b0;
                    r_hist       <= w_hist_next;
                    r_state      <= IDLE;
                end
                default: begin
                    r_pred_valid <= 1'b0;
                    r_state      <= IDLE;
                end
            endcase

            // A clear wins over the count of a record finishing this edge.
            if (i_clear_stats) begin
                r_total <= {STAT_W{1'b0}};
                r_miss  <= {STAT_W{1'b0}};
            end else if (r_state == UPDATE) begin
                r_total <= STAT_W'(sat_inc(32'(r_total), STAT_MAX));
                if (!r_pred_correct) begin
                    r_miss <= STAT_W'(sat_inc(32'(r_miss), STAT_MAX));
                end
            end
        end
    end

    assign bus.in_ready   = (r_state == IDLE);
    assign o_pred_valid   = r_pred_valid;
    assign o_pred_taken   = r_pred_taken;
    assign o_pred_correct = r_pred_correct;
    assign o_history      = r_hist;
    assign o_total_count  = r_total;
    assign o_miss_count   = r_miss;

endmodule

// File: tb/tb_branch_pred_core.sv
// -----------------------------------------------------------------------------
// tb_branch_pred_core
// Two cores side by side: index 0 is gshare (HIST_W=4, STAT_W=16), index 1 is
// bimodal with narrow statistics (HIST_W=0, STAT_W=2). A record-level model
// tracks each core's table, history and statistics; a negedge process compares
// every output against it, and directed sequences pin known values.
// -----------------------------------------------------------------------------
module tb_branch_pred_core;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        tv [2];
    logic        tt [2];
    logic        tc [2];
    logic [15:0] ta [2];

    branch_pred_core_if #(.ADDR_W(16)) bus_g ();
    branch_pred_core_if #(.ADDR_W(16)) bus_b ();

    assign bus_g.in_valid               = tv[0];
    assign bus_g.inst_addr              = ta[0];
    assign bus_g.direction_ground_truth = tt[0];
    assign bus_b.in_valid               = tv[1];
    assign bus_b.inst_addr              = ta[1];
    assign bus_b.direction_ground_truth = tt[1];

    logic        pv_g, pt_g, pc_g, pv_b, pt_b, pc_b;
    logic [3:0]  hist_g;
    logic [0:0]  hist_b;
    logic [15:0] tot_g, miss_g;
    logic [1:0]  tot_b, miss_b;

    branch_pred_core #(.ADDR_W(16), .IDX_W(4), .HIST_W(4), .CTR_W(2), .STAT_W(16)) dut_g (
        .clk(clk), .rst(rst), .bus(bus_g), .i_clear_stats(tc[0]),
        .o_pred_valid(pv_g), .o_pred_taken(pt_g), .o_pred_correct(pc_g),
        .o_history(hist_g), .o_total_count(tot_g), .o_miss_count(miss_g));

    branch_pred_core #(.ADDR_W(16), .IDX_W(4), .HIST_W(0), .CTR_W(2), .STAT_W(2)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b), .i_clear_stats(tc[1]),
        .o_pred_valid(pv_b), .o_pred_taken(pt_b), .o_pred_correct(pc_b),
        .o_history(hist_b), .o_total_count(tot_b), .o_miss_count(miss_b));

    int n_checks = 0;
    int n_err    = 0;
    bit cmp_en   = 1'b0;

    // ---------------- behavioural model ----------------
    int HW   [2] = '{4, 0};
    int SMAX [2] = '{65535, 3};
    int m_busy [2];   // cycles left before the core can accept again
    int m_hist [2];
    int m_tot  [2];
    int m_miss [2];
    int m_tbl  [2][16];
    int m_a    [2];
    int m_t    [2];
    int m_idx  [2];
    int m_pt   [2];
    int m_pc   [2];
    int m_acc  [2] = '{0, 0};
    longint acc_q [$];

    int strobes [2] = '{0, 0};
    logic last_pt [2];
    logic last_pc [2];

    always @(posedge clk or posedge rst) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_busy[d] = 0; m_hist[d] = 0; m_tot[d] = 0; m_miss[d] = 0;
                m_pt[d] = 0; m_pc[d] = 0;
                for (int i = 0; i < 16; i++) m_tbl[d][i] = 1;
            end else begin
                if (m_busy[d] == 2) begin
                    m_idx[d]  = (m_a[d] % 16) ^ ((HW[d] > 0) ? (m_hist[d] % 16) : 0);
                    m_pt[d]   = (m_tbl[d][m_idx[d]] >= 2) ? 1 : 0;
                    m_pc[d]   = (m_pt[d] == m_t[d]) ? 1 : 0;
                    m_busy[d] = 1;
                end else if (m_busy[d] == 1) begin
                    if (m_t[d] == 1) m_tbl[d][m_idx[d]] = (m_tbl[d][m_idx[d]] < 3) ? m_tbl[d][m_idx[d]] + 1 : 3;
                    else             m_tbl[d][m_idx[d]] = (m_tbl[d][m_idx[d]] > 0) ? m_tbl[d][m_idx[d]] - 1 : 0;
                    if (HW[d] > 0) m_hist[d] = (m_hist[d] * 2 + m_t[d]) % (1 << HW[d]);
                    if (!tc[d]) begin
                        if (m_tot[d] < SMAX[d]) m_tot[d]++;
                        if (m_pc[d] == 0 && m_miss[d] < SMAX[d]) m_miss[d]++;
                    end
                    m_busy[d] = 0;
                end else if (tv[d]) begin
                    m_a[d] = ta[d]; m_t[d] = tt[d]; m_busy[d] = 2;
                    m_acc[d]++;
                    if (d == 0) acc_q.push_back($time);
                end
                if (tc[d]) begin m_tot[d] = 0; m_miss[d] = 0; end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp(input int d, input logic rdy, input logic pv, input logic pt, input logic pc,
                       input logic [31:0] h, input logic [31:0] tot, input logic [31:0] ms);
        chk($sformatf("in_ready[%0d]", d), 64'(rdy), 64'(m_busy[d] == 0));
        chk($sformatf("pred_valid[%0d]", d), 64'(pv), 64'(m_busy[d] == 1));
        if (pv === 1'b1 && m_busy[d] == 1) begin
            chk($sformatf("pred_taken[%0d]", d), 64'(pt), 64'(m_pt[d]));
            chk($sformatf("pred_correct[%0d]", d), 64'(pc), 64'(m_pc[d]));
        end
        if (pv === 1'b1) begin
            strobes[d]++; last_pt[d] = pt; last_pc[d] = pc;
        end
        chk($sformatf("history[%0d]", d), 64'(h), 64'(m_hist[d]));
        chk($sformatf("total[%0d]", d), 64'(tot), 64'(m_tot[d]));
        chk($sformatf("miss[%0d]", d), 64'(ms), 64'(m_miss[d]));
    endtask

    // Single compare process: every output of both cores, every cycle.
    always @(negedge clk) begin
        if (cmp_en) begin
            cmp(0, bus_g.in_ready, pv_g, pt_g, pc_g, 32'(hist_g), 32'(tot_g), 32'(miss_g));
            cmp(1, bus_b.in_ready, pv_b, pt_b, pc_b, 32'(hist_b), 32'(tot_b), 32'(miss_b));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin tv[d] = 1'b0; tc[d] = 1'b0; end
        #1 rst = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    // Offer one record, optionally asserting clear_stats during its UPDATE cycle.
    task automatic send(input int d, input logic [15:0] a, input logic t, input logic clr);
        int n;
        n = 0;
        @(negedge clk);
        while (m_busy[d] != 0 && n < 20) begin @(negedge clk); n++; end
        chk("send_wait", 64'(n < 20), 64'd1);
        tv[d] = 1'b1; ta[d] = a; tt[d] = t;
        @(negedge clk); tv[d] = 1'b0;
        @(negedge clk); tc[d] = clr;
        @(negedge clk); tc[d] = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int s0, a0, n;
        for (int d = 0; d < 2; d++) begin tv[d] = 1'b0; tt[d] = 1'b0; tc[d] = 1'b0; ta[d] = 16'h0000; end
        #1 rst = 1'b1;
        #20 rst = 1'b0;
        cmp_en = 1'b1;
        @(negedge clk);
        chk("reset_ready", 64'(bus_g.in_ready), 64'd1);
        chk("reset_pv", 64'(pv_g), 64'd0);
        chk("reset_tot", 64'(tot_g), 64'd0);

        // Reset while a record is in LOOKUP: it must vanish without a strobe.
        @(negedge clk); tv[0] = 1'b1; ta[0] = 16'h0005; tt[0] = 1'b1;
        @(negedge clk); tv[0] = 1'b0;
        s0 = strobes[0];
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_no_strobe", 64'(strobes[0]), 64'(s0));
        chk("rst_ready", 64'(bus_g.in_ready), 64'd1);
        chk("rst_hist", 64'(hist_g), 64'd0);
        chk("rst_tot", 64'(tot_g), 64'd0);
        chk("rst_miss", 64'(miss_g), 64'd0);
        chk("rst_entry5", 64'(dut_g.u_tbl.r_ctr[5]), 64'd1);

        // gshare indexing on core 0.
        send(0, 16'h0003, 1'b1, 1'b0);
        chk("gs_hist1", 64'(hist_g), 64'd1);
        chk("gs_pt1", 64'(last_pt[0]), 64'd0);
        send(0, 16'h0003, 1'b1, 1'b0);
        chk("gs_pt2", 64'(last_pt[0]), 64'd0);
        chk("gs_miss2", 64'(miss_g), 64'd2);
        chk("gs_entry2", 64'(dut_g.u_tbl.r_ctr[2]), 64'd2);
        chk("gs_entry3", 64'(dut_g.u_tbl.r_ctr[3]), 64'd2);

        // Bimodal training on core 1.
        send(1, 16'h0010, 1'b1, 1'b0);
        chk("bim_pt1", 64'(last_pt[1]), 64'd0);
        chk("bim_pc1", 64'(last_pc[1]), 64'd0);
        send(1, 16'h0010, 1'b1, 1'b0);
        chk("bim_pt2", 64'(last_pt[1]), 64'd1);
        chk("bim_pc2", 64'(last_pc[1]), 64'd1);
        send(1, 16'h0010, 1'b1, 1'b0);
        chk("bim_pt3", 64'(last_pt[1]), 64'd1);
        chk("bim_pc3", 64'(last_pc[1]), 64'd1);
        chk("bim_tot", 64'(tot_b), 64'd3);
        chk("bim_miss", 64'(miss_b), 64'd1);
        chk("bim_entry0", 64'(dut_b.u_tbl.r_ctr[0]), 64'd3);
        send(1, 16'h0010, 1'b1, 1'b0);
        chk("bim_entry0_sat", 64'(dut_b.u_tbl.r_ctr[0]), 64'd3);
        chk("bim_tot_sat", 64'(tot_b), 64'd3);

        // Low saturation on core 1.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            send(1, 16'h0004, 1'b0, 1'b0);
            chk("low_pt", 64'(last_pt[1]), 64'd0);
            chk("low_pc", 64'(last_pc[1]), 64'd1);
        end
        chk("low_miss", 64'(miss_b), 64'd0);
        chk("low_entry4", 64'(dut_b.u_tbl.r_ctr[4]), 64'd0);

        // Narrow miss counter saturates: alternating outcomes always mispredict.
        for (int k = 0; k < 5; k++) begin
            send(1, 16'h0007, (k % 2 == 0) ? 1'b1 : 1'b0, 1'b0);
            chk("alt_pc", 64'(last_pc[1]), 64'd0);
        end
        chk("miss_sat", 64'(miss_b), 64'd3);

        // clear_stats coincident with UPDATE on core 0 (fresh since last reset).
        send(0, 16'h0009, 1'b1, 1'b1);
        chk("clr_tot", 64'(tot_g), 64'd0);
        chk("clr_miss", 64'(miss_g), 64'd0);
        chk("clr_hist", 64'(hist_g), 64'd1);

        // Streaming: in_valid held high, four records.
        s0 = strobes[0]; a0 = m_acc[0]; acc_q.delete(); n = 0;
        @(negedge clk);
        tv[0] = 1'b1;
        while (m_acc[0] - a0 < 4 && n < 40) begin
            if (m_busy[0] == 0) begin ta[0] = 16'($urandom); tt[0] = 1'($urandom_range(0, 1)); end
            @(negedge clk);
            n++;
        end
        tv[0] = 1'b0;
        chk("stream_bound", 64'(n < 40), 64'd1);
        repeat (4) @(negedge clk);
        chk("stream_strobes", 64'(strobes[0] - s0), 64'd4);
        chk("stream_accepts", 64'(acc_q.size()), 64'd4);
        for (int k = 1; k < acc_q.size(); k++) begin
            chk("stream_gap", 64'(acc_q[k] - acc_q[k-1]), 64'd30);
        end

        // Randomized traffic on both cores, compared every cycle.
        repeat (600) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                tv[d] = 1'($urandom_range(0, 1));
                ta[d] = 16'($urandom_range(0, 40));
                tt[d] = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
                tc[d] = ($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0;
            end
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin tv[d] = 1'b0; tc[d] = 1'b0; end
        repeat (4) @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            chk("tbl_g", 64'(dut_g.u_tbl.r_ctr[i]), 64'(m_tbl[0][i]));
            chk("tbl_b", 64'(dut_b.u_tbl.r_ctr[i]), 64'(m_tbl[1][i]));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
